// File: rtl/gc_eval_gate.sv
// gc_eval_gate: evaluator-side half-gates engine with free-XOR.
//
// Takes one gate descriptor at a time (gate code, two active input labels,
// two garbled-table rows) and produces the active output label. XOR-class
// gates are resolved locally in one cycle. AND-class gates issue two hash
// requests (label a, tweak 2j; label b, tweak 2j+1, j = num_and) to an
// external fixed-key hash unit, then combine the in-order responses with the
// table rows.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   g_valid/g_ready   descriptor handshake; g_logic, gid, in0_label,
//                     in1_label, t0 (TG row), t1 (TE row)
//   h_req_*           hash request (valid/ready, label, tweak)
//   h_resp_*          hash response (valid, data), in request order
//   o_valid/o_ready   output handshake; o_gid, o_label
//   num_and           number of AND-class gates evaluated (wraps mod 2^S)
//   err               sticky: a hash response arrived when none was expected
//
// Gate codes are the 4-bit truth table of f(a,b), bit index {a,b}:
// XOR=0110, XNOR=1001, NOT(a)=0011; every other code is AND-class.
module gc_eval_gate #(
  parameter int S = 20,
  parameter int K = 128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         g_valid,
  output logic         g_ready,
  input  logic [3:0]   g_logic,
  input  logic [S-1:0] gid,
  input  logic [K-1:0] in0_label,
  input  logic [K-1:0] in1_label,
  input  logic [K-1:0] t0,
  input  logic [K-1:0] t1,
  output logic         h_req_valid,
  input  logic         h_req_ready,
  output logic [K-1:0] h_req_label,
  output logic [S:0]   h_req_tweak,
  input  logic         h_resp_valid,
  input  logic [K-1:0] h_resp_data,
  output logic         o_valid,
  input  logic         o_ready,
  output logic [S-1:0] o_gid,
  output logic [K-1:0] o_label,
  output logic [S-1:0] num_and,
  output logic         err
);

  localparam logic [3:0] XORGATE  = 4'b0110;
  localparam logic [3:0] XNORGATE = 4'b1001;
  localparam logic [3:0] NOTGATE  = 4'b0011;

  typedef enum logic [2:0] {IDLE, REQ_A, REQ_B, WAIT, OUT} state_t;

  state_t       state, state_nx;
  logic [K-1:0] a_q, b_q, t0_q, t1_q, ha_q, hb_q;
  logic         is_and_q;
  logic [1:0]   resp_cnt;

  logic         is_xor_in;
  logic         resp_ok;
  logic         resp_bad;
  logic         and_done;
  logic [K-1:0] hb_eff;
  logic [K-1:0] and_label;

  // Response bookkeeping and the AND-class output label.
  always_comb begin
    is_xor_in = (g_logic == XORGATE) || (g_logic == XNORGATE) ||
                (g_logic == NOTGATE);
    resp_ok   = h_resp_valid && ((state == REQ_B) || (state == WAIT)) &&
                (resp_cnt != 2'd2);
    resp_bad  = h_resp_valid && !resp_ok;
    // The second response may land in the very cycle we leave WAIT, so the
    // combine uses it directly instead of the not-yet-written hb_q.
    and_done  = (resp_cnt == 2'd2) || ((resp_cnt == 2'd1) && resp_ok);
    hb_eff    = ((resp_cnt == 2'd1) && resp_ok) ? h_resp_data : hb_q;
    and_label = ha_q ^ (a_q[0] ? t0_q : '0) ^
                hb_eff ^ (b_q[0] ? (t1_q ^ a_q) : '0);
  end

  // Next state and handshake outputs.
  always_comb begin
    // NOTE: every output of this block gets a default first so that no path
    // leaves a signal unassigned, which would otherwise infer a latch.
    state_nx    = state;
    g_ready     = 1'b0;
    h_req_valid = 1'b0;
    h_req_label = a_q;
    h_req_tweak = {num_and, 1'b0};
    o_valid     = 1'b0;
    unique case (state)
      IDLE: begin
        // rst gating keeps the port low during the reset cycle itself.
        g_ready = !rst;
        if (g_valid) state_nx = is_xor_in ? OUT : REQ_A;
      end
      REQ_A: begin
        h_req_valid = 1'b1;
        if (h_req_ready) state_nx = REQ_B;
      end
      REQ_B: begin
        h_req_valid = 1'b1;
        h_req_label = b_q;
        h_req_tweak = {num_and, 1'b1};
        if (h_req_ready) state_nx = WAIT;
      end
      WAIT: begin
        if (and_done) state_nx = OUT;
      end
      OUT: begin
        o_valid = 1'b1;
        if (o_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      t0_q     <= '0;
      t1_q     <= '0;
      ha_q     <= '0;
      hb_q     <= '0;
      is_and_q <= 1'b0;
      resp_cnt <= 2'd0;
      o_gid    <= '0;
      o_label  <= '0;
      num_and  <= '0;
      err      <= 1'b0;
    end else begin
      state <= state_nx;
      if (resp_bad) err <= 1'b1;
      if (resp_ok) begin
        resp_cnt <= resp_cnt + 2'd1;
        if (resp_cnt == 2'd0) ha_q <= h_resp_data;
        else                  hb_q <= h_resp_data;
      end
      unique case (state)
        IDLE: begin
          if (g_valid) begin
            a_q      <= in0_label;
            b_q      <= in1_label;
            t0_q     <= t0;
            t1_q     <= t1;
            is_and_q <= !is_xor_in;
            o_gid    <= gid;
            // Free-XOR: inversion is folded in by the garbler.
            if (is_xor_in) o_label <= in0_label ^ in1_label;
          end
        end
        WAIT: begin
          if (and_done) o_label <= and_label;
        end
        OUT: begin
          if (o_ready) begin
            resp_cnt <= 2'd0;
            if (is_and_q) num_and <= num_and + {{(S-1){1'b0}}, 1'b1};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gc_eval_gate.sv
// Self-checking bench for gc_eval_gate: table of directed gate vectors with
// hand-computed labels, plus hand-written sequences for backpressure,
// response timing, spurious responses and mid-gate reset.
module tb_gc_eval_gate;

  localparam int S = 20;
  localparam int K = 128;

  localparam logic [3:0] XOR_C  = 4'b0110;
  localparam logic [3:0] XNOR_C = 4'b1001;
  localparam logic [3:0] NOT_C  = 4'b0011;
  localparam logic [3:0] AND_C  = 4'b1000;
  localparam logic [3:0] OR_C   = 4'b1110;

  logic         clk = 1'b0;
  logic         rst;
  logic         g_valid;
  logic         g_ready;
  logic [3:0]   g_logic;
  logic [S-1:0] gid;
  logic [K-1:0] in0_label, in1_label, t0, t1;
  logic         h_req_valid, h_req_ready;
  logic [K-1:0] h_req_label;
  logic [S:0]   h_req_tweak;
  logic         h_resp_valid;
  logic [K-1:0] h_resp_data;
  logic         o_valid, o_ready;
  logic [S-1:0] o_gid;
  logic [K-1:0] o_label;
  logic [S-1:0] num_and;
  logic         err;

  gc_eval_gate #(.S(S), .K(K)) dut (
    .clk(clk), .rst(rst),
    .g_valid(g_valid), .g_ready(g_ready), .g_logic(g_logic), .gid(gid),
    .in0_label(in0_label), .in1_label(in1_label), .t0(t0), .t1(t1),
    .h_req_valid(h_req_valid), .h_req_ready(h_req_ready),
    .h_req_label(h_req_label), .h_req_tweak(h_req_tweak),
    .h_resp_valid(h_resp_valid), .h_resp_data(h_resp_data),
    .o_valid(o_valid), .o_ready(o_ready), .o_gid(o_gid), .o_label(o_label),
    .num_and(num_and), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   code;
    logic         is_and;
    logic [S-1:0] id;
    logic [K-1:0] a, b, ta, tb, ha, hb, exp;
  } vec_t;

  vec_t         vecs[8];
  int           n_tests = 0;
  int           n_fail  = 0;
  logic [S-1:0] exp_nand = '0;

  task automatic check(input string name, input logic [K-1:0] act,
                       input logic [K-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Advance one clock; outputs are examined 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_gate(input vec_t v);
    g_valid   = 1'b1;
    g_logic   = v.code;
    gid       = v.id;
    in0_label = v.a;
    in1_label = v.b;
    t0        = v.ta;
    t1        = v.tb;
    tick();
    g_valid   = 1'b0;
  endtask

  task automatic run_gate(input vec_t v, input string tag);
    check({tag, " g_ready idle"}, K'(g_ready), K'(1));
    drive_gate(v);
    check({tag, " g_ready busy"}, K'(g_ready), K'(0));
    if (v.is_and) begin
      check({tag, " reqA valid"}, K'(h_req_valid), K'(1));
      check({tag, " reqA label"}, h_req_label, v.a);
      check({tag, " reqA tweak"}, K'(h_req_tweak), K'({exp_nand, 1'b0}));
      h_req_ready = 1'b1;
      tick();
      check({tag, " reqB label"}, h_req_label, v.b);
      check({tag, " reqB tweak"}, K'(h_req_tweak), K'({exp_nand, 1'b1}));
      tick();
      h_req_ready = 1'b0;
      check({tag, " no req in wait"}, K'(h_req_valid), K'(0));
      h_resp_valid = 1'b1;
      h_resp_data  = v.ha;
      tick();
      h_resp_data  = v.hb;
      tick();
      h_resp_valid = 1'b0;
      exp_nand = exp_nand + 1'b1;
    end
    check({tag, " o_valid"}, K'(o_valid), K'(1));
    check({tag, " o_label"}, o_label, v.exp);
    check({tag, " o_gid"}, K'(o_gid), K'(v.id));
    o_ready = 1'b1;
    tick();
    o_ready = 1'b0;
    check({tag, " o_valid drop"}, K'(o_valid), K'(0));
    check({tag, " num_and"}, K'(num_and), K'(exp_nand));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    //           code    and   id      a              b              t0        t1        hA         hB         expected
    vecs[0] = '{XOR_C,  1'b0, 20'd5,  128'hF0,       128'h0F,       '0,       '0,       '0,        '0,        128'hFF};
    vecs[1] = '{AND_C,  1'b1, 20'd6,  128'h10,       128'h20,       '0,       '0,       128'hAA,   128'h55,   128'hFF};
    vecs[2] = '{AND_C,  1'b1, 20'd7,  128'h11,       128'h21,       128'h100, 128'h200, '0,        '0,        128'h311};
    vecs[3] = '{XNOR_C, 1'b0, 20'd8,  128'h1234,     128'h00FF,     '0,       '0,       '0,        '0,        128'h12CB};
    vecs[4] = '{NOT_C,  1'b0, 20'd9,  128'hABCD,     128'hFFFF,     '0,       '0,       '0,        '0,        128'h5432};
    vecs[5] = '{AND_C,  1'b1, 20'd10, 128'h3,        128'h4,        128'hF00, 128'h123, 128'h1000, 128'h2000, 128'h3F00};
    vecs[6] = '{OR_C,   1'b1, 20'd11, 128'h40,       128'h81,       128'h5,   128'h700, 128'h1,    128'h2,    128'h743};
    vecs[7] = '{XOR_C,  1'b0, 20'hFFFFF, {K{1'b1}},  128'h1,        '0,       '0,       '0,        '0,
                128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE};

    rst = 1'b1; g_valid = 1'b0; g_logic = '0; gid = '0;
    in0_label = '0; in1_label = '0; t0 = '0; t1 = '0;
    h_req_ready = 1'b0; h_resp_valid = 1'b0; h_resp_data = '0; o_ready = 1'b0;

    // Reset state.
    tick();
    tick();
    check("rst g_ready", K'(g_ready), K'(0));
    check("rst h_req_valid", K'(h_req_valid), K'(0));
    check("rst o_valid", K'(o_valid), K'(0));
    check("rst o_gid", K'(o_gid), K'(0));
    check("rst o_label", o_label, '0);
    check("rst num_and", K'(num_and), K'(0));
    check("rst err", K'(err), K'(0));
    rst = 1'b0;
    tick();
    check("post-rst g_ready", K'(g_ready), K'(1));

    for (int i = 0; i < 8; i++) run_gate(vecs[i], $sformatf("vec%0d", i));
    check("err after table", K'(err), K'(0));

    // AND gate with request and output backpressure; two responses, the
    // second coinciding with the REQ_B handshake.
    v = '{AND_C, 1'b1, 20'd42, 128'h5, 128'h6, 128'h50, '0, 128'h1111, 128'h2222, 128'h3363};
    drive_gate(v);
    for (int i = 0; i < 3; i++) begin
      check("bp reqA valid", K'(h_req_valid), K'(1));
      check("bp reqA label", h_req_label, v.a);
      check("bp reqA tweak", K'(h_req_tweak), K'({exp_nand, 1'b0}));
      tick();
    end
    h_req_ready = 1'b1;
    tick();
    check("bp reqB label", h_req_label, v.b);
    check("bp reqB tweak", K'(h_req_tweak), K'({exp_nand, 1'b1}));
    h_req_ready  = 1'b0;
    h_resp_valid = 1'b1;
    h_resp_data  = v.ha;
    tick();
    check("bp reqB held", K'(h_req_valid), K'(1));
    check("bp reqB label held", h_req_label, v.b);
    h_req_ready = 1'b1;
    h_resp_data = v.hb;
    tick();
    h_req_ready  = 1'b0;
    h_resp_valid = 1'b0;
    check("bp wait no req", K'(h_req_valid), K'(0));
    check("bp wait no out", K'(o_valid), K'(0));
    check("bp no err", K'(err), K'(0));
    tick();
    exp_nand = exp_nand + 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("bp o_valid held", K'(o_valid), K'(1));
      check("bp o_label held", o_label, v.exp);
      check("bp o_gid held", K'(o_gid), K'(v.id));
      check("bp g_ready low", K'(g_ready), K'(0));
      tick();
    end
    o_ready = 1'b1;
    tick();
    o_ready = 1'b0;
    check("bp o_valid drop", K'(o_valid), K'(0));
    check("bp num_and", K'(num_and), K'(exp_nand));
    check("bp err", K'(err), K'(0));

    // Spurious response in IDLE sets the sticky error.
    h_resp_valid = 1'b1;
    h_resp_data  = 128'hDEAD;
    tick();
    h_resp_valid = 1'b0;
    check("spurious err set", K'(err), K'(1));
    run_gate(vecs[0], "after-err");
    check("err sticky", K'(err), K'(1));

    // Reset while waiting on the second hash response.
    v = '{AND_C, 1'b1, 20'd77, 128'h9, 128'hA, '0, '0, '0, '0, '0};
    drive_gate(v);
    h_req_ready = 1'b1;
    tick();
    tick();
    h_req_ready  = 1'b0;
    h_resp_valid = 1'b1;
    h_resp_data  = 128'h77;
    tick();
    h_resp_valid = 1'b0;
    check("mid wait o_valid", K'(o_valid), K'(0));
    check("mid wait no req", K'(h_req_valid), K'(0));
    rst = 1'b1;
    tick();
    check("abort g_ready in rst", K'(g_ready), K'(0));
    check("abort o_valid", K'(o_valid), K'(0));
    check("abort num_and", K'(num_and), K'(0));
    check("abort err", K'(err), K'(0));
    check("abort h_req_valid", K'(h_req_valid), K'(0));
    rst = 1'b0;
    exp_nand = '0;
    tick();
    run_gate(vecs[1], "post-abort");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
